// File: rtl/axi_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_slave_pkg
// Brief    : Shared constants, state encodings and address-advance helper
// Revision : 1.0 - initial release
// ============================================================================
package axi_sram_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RBURST = 2'd1;
    localparam state_t ST_WDATA  = 2'd2;
    localparam state_t ST_WRESP  = 2'd3;

    // WRAP is deliberately handled as INCR; sizes above 4 bytes clamp to 4.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [2:0]  eff_size;
        logic [31:0] step;
        eff_size = (size > 3'd2) ? 3'd2 : size;
        step     = 32'd1 << eff_size;
        case (burst)
            BURST_FIXED:            next_addr = addr;
            BURST_INCR, BURST_WRAP: next_addr = addr + step;
            default:                next_addr = addr + step;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_sram_mem.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_mem
// Brief    : MEM_WORDS x 32 storage, byte-enable sync write, async read
// Revision : 1.0 - initial release
// ============================================================================
module axi_sram_mem #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [0:MEM_WORDS-1];

    // Contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_slave
// Brief    : AXI3 slave serving one burst at a time from a 32-bit SRAM
// Revision : 1.0 - initial release
// ============================================================================
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int c_idx_w = $clog2(MEM_WORDS);

    state_t              r_state;
    logic [3:0]          r_id;
    logic [31:0]         r_addr;
    logic [3:0]          r_len;
    logic [3:0]          r_cnt;
    logic [2:0]          r_size;
    logic [1:0]          r_burst;
    logic                r_err;
    logic                r_rvalid;
    logic                r_rlast;
    logic [31:0]         r_rdata;
    logic [3:0]          r_rid;
    logic [1:0]          r_rresp;
    logic                r_wready;
    logic                r_bvalid;
    logic [3:0]          r_bid;
    logic [1:0]          r_bresp;

    logic [31:0]         w_next_addr;
    logic                w_last_beat;
    logic                w_err_next;
    logic                w_we;
    logic [c_idx_w-1:0]  w_raddr;
    logic [c_idx_w-1:0]  w_waddr;
    logic [31:0]         w_mem_rdata;
    logic                w_unused;

    assign w_next_addr = next_addr(r_addr, r_size, r_burst);
    assign w_last_beat = (r_cnt == r_len);
    assign w_err_next  = r_err | (wlast != w_last_beat);

    // In IDLE the read port looks at the incoming AR address; in a read burst
    // it looks ahead so the next beat can be loaded on the current handshake.
    assign w_raddr = (r_state == ST_IDLE) ? araddr[c_idx_w+1:2]
                                          : w_next_addr[c_idx_w+1:2];
    assign w_waddr = r_addr[c_idx_w+1:2];
    assign w_we    = r_wready && wvalid && !rst;

    assign arready = !rst && (r_state == ST_IDLE);
    assign awready = !rst && (r_state == ST_IDLE) && !arvalid;

    assign rid    = r_rid;
    assign rdata  = r_rdata;
    assign rresp  = r_rresp;
    assign rlast  = r_rlast;
    assign rvalid = r_rvalid;
    assign wready = r_wready;
    assign bid    = r_bid;
    assign bresp  = r_bresp;
    assign bvalid = r_bvalid;

    assign w_unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    axi_sram_mem #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (c_idx_w)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (wdata),
        .i_wstrb (wstrb),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_err    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
            r_rresp  <= '0;
            r_wready <= 1'b0;
            r_bvalid <= 1'b0;
            r_bid    <= '0;
            r_bresp  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arvalid) begin
                        r_id     <= arid;
                        r_addr   <= araddr;
                        r_len    <= arlen;
                        r_size   <= arsize;
                        r_burst  <= arburst;
                        r_cnt    <= '0;
                        r_rdata  <= w_mem_rdata;
                        r_rid    <= arid;
                        r_rresp  <= RESP_OKAY;
                        r_rvalid <= 1'b1;
                        r_rlast  <= (arlen == 4'd0);
                        r_state  <= ST_RBURST;
                    end else if (awvalid) begin
                        r_id     <= awid;
                        r_addr   <= awaddr;
                        r_len    <= awlen;
                        r_size   <= awsize;
                        r_burst  <= awburst;
                        r_cnt    <= '0;
                        r_err    <= 1'b0;
                        r_wready <= 1'b1;
                        r_state  <= ST_WDATA;
                    end
                end
                ST_RBURST: begin
                    if (rready) begin
                        if (w_last_beat) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_addr   <= w_next_addr;
                            r_cnt    <= r_cnt + 4'd1;
                            r_rdata  <= w_mem_rdata;
                            r_rlast  <= ((r_cnt + 4'd1) == r_len);
                        end
                    end
                end
                ST_WDATA: begin
                    // Burst length comes from awlen alone; wlast only flags errors.
                    if (wvalid) begin
                        r_err <= w_err_next;
                        if (w_last_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_id;
                            r_bresp  <= w_err_next ? RESP_SLVERR : RESP_OKAY;
                            r_state  <= ST_WRESP;
                        end else begin
                            r_addr   <= w_next_addr;
                            r_cnt    <= r_cnt + 4'd1;
                        end
                    end
                end
                ST_WRESP: begin
                    if (bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_sram_slave
// Brief    : Self-checking bench for axi_sram_slave against a memory model
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

    localparam int MEM_WORDS = 256;
    localparam int IDX_W     = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [MEM_WORDS];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    axi_sram_slave #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // Word index of beat n: start + n * bytes_per_beat, then address bits [IDX_W+1:2].
    function automatic int beat_index(input logic [31:0] addr, input logic [2:0] size,
                                      input logic [1:0] burst, input int beat);
        logic [31:0] a;
        int          step;
        step = (size >= 3'd3) ? 4 : (1 << size);
        a    = (burst == 2'b00) ? addr : addr + 32'(beat * step);
        return int'(a[IDX_W+1:2]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int bad_wlast, input bit rnd);
        int          n;
        int          idx;
        bit          exp_err;
        bit          wl;
        bit          early;
        logic [1:0]  exp_resp;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awlock = 2'($urandom); awcache = 4'($urandom); awprot = 3'($urandom);
        awvalid = 1'b1;
        #1;
        n = 0;
        while (awready !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL aw_timeout: awready=%b required 1", awready);
        end
        tick();
        awvalid = 1'b0;
        exp_err = 1'b0;
        early = rnd && ($urandom_range(0, 1) == 1);
        bready = early;
        for (int i = 0; i <= int'(len); i++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) tick();
            end
            wl = (bad_wlast < 0) ? (i == int'(len)) : (i == bad_wlast);
            if (wl != (i == int'(len))) exp_err = 1'b1;
            wdata = wd[i]; wstrb = ws[i]; wlast = wl; wid = 4'($urandom);
            wvalid = 1'b1;
            checks++;
            if (wready !== 1'b1) begin
                errors++;
                $display("FAIL wready beat %0d: got %b required 1", i, wready);
            end
            tick();
            wvalid = 1'b0;
            idx = beat_index(addr, size, burst, i);
            for (int b = 0; b < 4; b++) begin
                if (ws[i][b]) model_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        exp_resp = exp_err ? 2'b10 : 2'b00;
        if (!early) begin
            repeat ($urandom_range(0, 2)) begin
                checks++;
                if (bvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL bvalid_hold: got %b required 1", bvalid);
                end
                tick();
            end
        end
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL bvalid: got %b required 1", bvalid);
        end
        checks++;
        if (bresp !== exp_resp) begin
            errors++;
            $display("FAIL bresp: got %b required %b", bresp, exp_resp);
        end
        checks++;
        if (bid !== id) begin
            errors++;
            $display("FAIL bid: got %h required %h", bid, id);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL bvalid_after_b: got %b required 0", bvalid);
        end
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_len, input bit rnd);
        int          n;
        int          stalls;
        logic [31:0] exp;
        logic        exp_last;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arlock = 2'($urandom); arcache = 4'($urandom); arprot = 3'($urandom);
        arvalid = 1'b1;
        rready = 1'b0;
        #1;
        n = 0;
        while (arready !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL ar_timeout: arready=%b required 1", arready);
        end
        tick();
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL first_beat_latency: rvalid=%b required 1", rvalid);
        end
        for (int i = 0; i <= int'(len); i++) begin
            exp      = model_mem[beat_index(addr, size, burst, i)];
            exp_last = (i == int'(len));
            stalls   = (i == stall_beat) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            rready   = 1'b0;
            for (int s = 0; s < stalls; s++) begin
                tick();
                checks++;
                if (rvalid !== 1'b1 || rdata !== exp || rlast !== exp_last) begin
                    errors++;
                    $display("FAIL stall_hold beat %0d: rvalid=%b rdata=%h rlast=%b required 1 %h %b",
                             i, rvalid, rdata, rlast, exp, exp_last);
                end
            end
            rready = 1'b1;
            checks++;
            if (rvalid !== 1'b1) begin
                errors++;
                $display("FAIL rvalid beat %0d: got %b required 1", i, rvalid);
            end
            checks++;
            if (rdata !== exp) begin
                errors++;
                $display("FAIL rdata beat %0d: got %h required %h", i, rdata, exp);
            end
            checks++;
            if (rlast !== exp_last) begin
                errors++;
                $display("FAIL rlast beat %0d: got %b required %b", i, rlast, exp_last);
            end
            checks++;
            if (rid !== id || rresp !== 2'b00) begin
                errors++;
                $display("FAIL rid_rresp beat %0d: got %h/%b required %h/00", i, rid, rresp, id);
            end
            checks++;
            if (awready !== 1'b0) begin
                errors++;
                $display("FAIL awready_in_read beat %0d: got %b required 0", i, awready);
            end
            tick();
        end
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_after_last: got %b required 0", rvalid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = '0; arcache = '0; arprot = '0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awlock = '0; awcache = '0; awprot = '0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0;
        repeat (3) tick();
        checks++;
        if (arready !== 1'b0 || awready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: arready=%b awready=%b required 0 0", arready, awready);
        end
        checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || bvalid !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: rvalid=%b rlast=%b bvalid=%b wready=%b required 0",
                     rvalid, rlast, bvalid, wready);
        end
        checks++;
        if (rdata !== 32'h0 || rid !== 4'h0 || rresp !== 2'b00 || bid !== 4'h0 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_data: rdata=%h rid=%h rresp=%b bid=%h bresp=%b required 0",
                     rdata, rid, rresp, bid, bresp);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (arready !== 1'b1 || awready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: arready=%b awready=%b required 1 1", arready, awready);
        end
    endtask

    task automatic test_fill();
        for (int blk = 0; blk < MEM_WORDS / 16; blk++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(4'(blk), 32'(blk * 64), 4'd15, 3'd2, 2'b01, -1, 1'b0);
        end
    endtask

    task automatic test_incr_burst();
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h11111111 * (i + 1); ws[i] = 4'hF; end
        do_write(4'h3, 32'h100, 4'd7, 3'd2, 2'b01, -1, 1'b0);
        do_read(4'h5, 32'h100, 4'd7, 3'd2, 2'b01, -1, 0, 1'b0);
    endtask

    task automatic test_read_stall();
        do_read(4'h6, 32'h100, 4'd7, 3'd2, 2'b01, 2, 3, 1'b0);
    endtask

    task automatic test_byte_write();
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        do_write(4'h1, 32'h200, 4'd0, 3'd2, 2'b01, -1, 1'b0);
        wd[0] = 32'h000000AB; ws[0] = 4'b0001;
        do_write(4'h2, 32'h200, 4'd0, 3'd0, 2'b01, -1, 1'b0);
        do_read(4'h7, 32'h200, 4'd0, 3'd2, 2'b01, -1, 0, 1'b0);
    endtask

    task automatic test_priority();
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        awid = 4'h9; awaddr = 32'h140; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01;
        awvalid = 1'b1;
        arid = 4'hA; araddr = 32'h140; arlen = 4'd3; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        #1;
        checks++;
        if (arready !== 1'b1 || awready !== 1'b0) begin
            errors++;
            $display("FAIL priority: arready=%b awready=%b required 1 0", arready, awready);
        end
        do_read(4'hA, 32'h140, 4'd3, 3'd2, 2'b01, -1, 0, 1'b0);
        checks++;
        if (awready !== 1'b1) begin
            errors++;
            $display("FAIL awready_after_read: got %b required 1", awready);
        end
        do_write(4'h9, 32'h140, 4'd3, 3'd2, 2'b01, -1, 1'b0);
        do_read(4'hB, 32'h140, 4'd3, 3'd2, 2'b01, -1, 0, 1'b0);
    endtask

    task automatic test_wlast_mismatch();
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'hC, 32'h300, 4'd3, 3'd2, 2'b01, 1, 1'b0);
        do_read(4'hD, 32'h300, 4'd3, 3'd2, 2'b01, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] exp;
        arid = 4'h4; araddr = 32'h100; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (3) tick();
        rready = 1'b0;
        exp = model_mem[beat_index(32'h100, 3'd2, 2'b01, 3)];
        checks++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            errors++;
            $display("FAIL beat4_before_reset: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, exp);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'h0 || arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst: rvalid=%b rlast=%b rdata=%h arready=%b required 0 0 0 0",
                     rvalid, rlast, rdata, arready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: arready=%b rvalid=%b required 1 0", arready, rvalid);
        end
        do_read(4'h8, 32'h100, 4'd7, 3'd2, 2'b01, -1, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          bad;
        for (int t = 0; t < 40; t++) begin
            id    = 4'($urandom);
            addr  = $urandom;
            len   = 4'($urandom_range(0, 15));
            size  = 3'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
                do_write(id, addr, len, size, burst, bad, 1'b1);
            end else begin
                do_read(id, addr, len, size, burst, -1, 0, 1'b1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_incr_burst();
        test_read_stall();
        test_byte_write();
        test_priority();
        test_wlast_mismatch();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, giving the depth of the 32-bit memory in words (power of two).
REQ-002 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have the AR channel: arid in 4, araddr in 32, arlen in 4, arsize in 3, arburst in 2, arlock in 2, arcache in 4, arprot in 3, arvalid in 1, arready out 1.
REQ-005 SHALL have the R channel: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-006 SHALL have the AW channel: awid in 4, awaddr in 32, awlen in 4, awsize in 3, awburst in 2, awlock in 2, awcache in 4, awprot in 3, awvalid in 1, awready out 1.
REQ-007 SHALL have the W channel: wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
REQ-008 SHALL have the B channel: bid out 4, bresp out 2, bvalid out 1, bready in 1.
REQ-009 SHALL ignore the *lock, *cache, *prot and wid inputs.

Function
REQ-010 SHALL process one transaction at a time using a state machine with states IDLE, RBURST, WDATA and WRESP.
REQ-011 SHALL drive arready = (state==IDLE) and awready = (state==IDLE and not arvalid); both SHALL be 0 while rst is high.
REQ-012 SHALL give read priority: when arvalid and awvalid are both high in IDLE, the AR request is accepted and the AW request waits.
REQ-013 On AR handshake, SHALL latch id, addr, len, size and burst, clear the beat counter, load rdata with mem[addr word index], and enter RBURST.
REQ-014 In RBURST, SHALL hold rvalid=1, rid=latched id, rresp=2'b00 and rlast=(cnt==len).
REQ-015 SHALL keep rdata, rlast and rvalid stable while rvalid is high and rready is low.
REQ-016 On an R handshake that is not the last beat, SHALL advance the address, increment cnt and load rdata with the next word in the same cycle, giving one beat per cycle while rready stays high.
REQ-017 On the R handshake of the last beat, SHALL enter IDLE with rvalid=0 on the next cycle.
REQ-018 First-beat read latency SHALL be exactly 1 cycle from the AR handshake to rvalid.
REQ-019 On AW handshake, SHALL latch id, addr, len, size and burst, clear cnt, clear the error flag, and enter WDATA.
REQ-020 In WDATA, SHALL hold wready=1; on each W handshake, SHALL write only the byte lanes of mem[word index] whose wstrb bits are set.
REQ-021 Beat count SHALL be governed by awlen; wlast SHALL NOT terminate a burst, and a mismatch between wlast and (cnt==len) SHALL set the error flag.
REQ-022 After the W handshake with cnt==len, SHALL enter WRESP.
REQ-023 In WRESP, SHALL hold bvalid=1, bid=latched id and bresp=2'b10 if the error flag is set, else 2'b00; on bready, SHALL enter IDLE.
REQ-024 SHALL accept bready asserted before bvalid; the handshake completes in the first cycle both are high.
REQ-025 Address advance SHALL be: burst 2'b00 (FIXED) no change; 2'b01 (INCR) and 2'b10 (WRAP, treated as INCR) add (1<<size) modulo 2^32.
REQ-026 Word index SHALL be addr[log2(MEM_WORDS)+1:2]; higher bits SHALL be ignored, so addresses alias modulo 4*MEM_WORDS and low address bits never fault.
REQ-027 Bursts SHALL be 1..16 beats (len+1); size 3'b011 or larger SHALL be treated as 3'b010.
REQ-028 wvalid deasserting between beats SHALL stall without losing beats; rready deasserting SHALL stall without skipping beats.

Reset
REQ-029 While rst is high, the next edge SHALL force state=IDLE, cnt=0, error=0, and rvalid, rlast, bvalid, wready, rdata, rid, rresp, bid and bresp to 0.
REQ-030 Reset mid-burst SHALL abandon the burst with no further beats or responses.
REQ-031 Memory contents SHALL NOT be reset; writes already completed SHALL persist.

Structure
REQ-032 The shared header SHALL hold BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR and the state encodings.
REQ-033 The storage SHALL be one sub-module axi_sram_mem: MEM_WORDS x 32, one synchronous byte-enable write port and one read port.

Verification
REQ-034 Write 0x11111111..0x88888888 with INCR awlen=7 to 0x100, then read it back with INCR arlen=7 -> rdata matches in order, rlast only on beat 8, bresp=00, rresp=00.
REQ-035 Hold rready low for 3 cycles at beat 3 of an 8-beat read -> beat 3 data held stable and no beat lost or duplicated.
REQ-036 Single write awsize=0 wstrb=0001 wdata=0xAB to 0x200 holding 0xFFFFFFFF -> readback 0xFFFFFFAB.
REQ-037 Assert arvalid and awvalid in the same IDLE cycle -> the read completes first, then the write is accepted with awready rising only after the read returns to IDLE.
REQ-038 4-beat write with wlast on beat 2 -> 4 beats are written and bresp=2'b10.
REQ-039 Assert rst during beat 4 of an 8-beat read -> rvalid=0 next cycle, state IDLE, and previously written memory unchanged on a subsequent read.
